// File: rtl/prog_ram_pkg.sv
// Shared types for the program/data RAM and its load FSM.
// Imported by the RAM top level.
package prog_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } prog_ram_state_t;

endpackage

// File: rtl/prog_ram_if.sv
// CPU bus and byte-stream load port of the program RAM.
// master = CPU/loader side, slave = RAM side.
interface prog_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic              prog_mode;
  logic              w_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;
  logic              ld_done;
  logic              busy;

  modport master (
    output prog_mode, w_en, address, w_data,
    output ld_valid, ld_data,
    input  r_data, ld_ready, ld_count,
    input  ld_done, busy
  );

  modport slave (
    input  prog_mode, w_en, address, w_data,
    input  ld_valid, ld_data,
    output r_data, ld_ready, ld_count,
    output ld_done, busy
  );

endinterface

// File: rtl/prog_ram_edge_detector.sv
// Registered rising/falling edge detector.
// Each output pulses one cycle after the input changes.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  output logic rising_edge_o,
  output logic falling_edge_o
);

  logic a_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q            <= 1'b0;
      rising_edge_o  <= 1'b0;
      falling_edge_o <= 1'b0;
    end else begin
      a_q            <= a_i;
      rising_edge_o  <= a_i & ~a_q;
      falling_edge_o <= ~a_i & a_q;
    end
  end

endmodule

// File: rtl/prog_ram.sv
// Single-port program/data RAM with a serial load port.
// CPU writes are blocked while a load is in progress.
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RD_BYP = 0
) (
  input  logic          clk,
  input  logic          rst,
  prog_ram_if.slave     bus
);

  localparam int DEPTH = 1 << ADDR_W;

  prog_ram_state_t   state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic              done_q;
  logic              busy_q;
  logic [DATA_W-1:0] r_q;
  logic              rise;
  logic              fall_unused;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              ld_rdy;
  logic              ld_fire;
  logic              cpu_we;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  edge_detector u_edge (
    .clk            (clk),
    .rst            (rst),
    .a_i            (bus.prog_mode),
    .rising_edge_o  (rise),
    .falling_edge_o (fall_unused)
  );

  assign ld_rdy  = (state == ST_LOAD);
  assign ld_fire = ld_rdy & bus.ld_valid;
  assign cpu_we  = bus.w_en & (state == ST_IDLE)
                 & ~bus.prog_mode;

  // Loader owns the single write port while it streams.
  assign we = ld_fire | cpu_we;
  assign wa = ld_fire ? ptr : bus.address;
  assign wd = ld_fire ? bus.ld_data : bus.w_data;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (RD_BYP != 0 && we
                 && wa == bus.address) begin
      r_q <= wd;
    end else begin
      r_q <= mem[bus.address];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rise) begin
            state  <= ST_LOAD;
            busy_q <= 1'b1;
            ptr    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ld_fire) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt + 1'b1;
          end
          if (!bus.prog_mode) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (ld_fire && &ptr) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.prog_mode) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r_data   = r_q;
  assign bus.ld_ready = ld_rdy;
  assign bus.ld_count = cnt;
  assign bus.ld_done  = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_prog_ram.sv
// Directed/random bench for prog_ram against a memory-array model.
// Two instances share stimulus: read-old and write-first.
module tb_prog_ram;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  prog_ram_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  prog_ram_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

  prog_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_BYP(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  prog_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_BYP(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  assign b1.prog_mode = b0.prog_mode;
  assign b1.w_en      = b0.w_en;
  assign b1.address   = b0.address;
  assign b1.w_data    = b0.w_data;
  assign b1.ld_valid  = b0.ld_valid;
  assign b1.ld_data   = b0.ld_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH];
  int m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdata"}, b0.r_data, 0);
    chk({tag, "_ready"}, b0.ld_ready, 0);
    chk({tag, "_count"}, b0.ld_count, 0);
    chk({tag, "_done"}, b0.ld_done, 0);
    chk({tag, "_busy"}, b0.busy, 0);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      b0.address = AW'(a);
      tick;
      chk(tag, b0.r_data, ref_mem[a]);
    end
  endtask

  task automatic start_load;
    b0.prog_mode = 1'b1;
    tick;
    chk("edge_delay_ready", b0.ld_ready, 0);
    tick;
    chk("load_ready", b0.ld_ready, 1);
    chk("load_busy", b0.busy, 1);
    chk("load_count0", b0.ld_count, 0);
    chk("load_done0", b0.ld_done, 0);
    m_cnt = 0;
  endtask

  task automatic beat(input logic v, input logic [7:0] d);
    b0.ld_valid = v;
    b0.ld_data  = d;
    tick;
    b0.ld_valid = 1'b0;
    if (v && m_cnt < DEPTH) begin
      ref_mem[m_cnt] = d;
      m_cnt++;
    end
    chk("beat_count", b0.ld_count, m_cnt);
    chk("beat_done", b0.ld_done, m_cnt == DEPTH);
    chk("beat_ready", b0.ld_ready, m_cnt < DEPTH);
  endtask

  task automatic exit_load(input string tag);
    b0.ld_valid  = 1'b0;
    b0.prog_mode = 1'b0;
    tick;
    chk({tag, "_busy"}, b0.busy, 0);
    chk({tag, "_ready"}, b0.ld_ready, 0);
    chk({tag, "_done"}, b0.ld_done, 0);
    chk({tag, "_count"}, b0.ld_count, m_cnt);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] old;
    b0.prog_mode = 1'b0;
    b0.w_en      = 1'b0;
    b0.address   = '0;
    b0.w_data    = '0;
    b0.ld_valid  = 1'b0;
    b0.ld_data   = '0;
    m_cnt        = 0;

    #12;
    chk_reset_outs("reset");
    rst = 1'b1;
    tick;

    b0.address = 4'd3;
    b0.w_data  = 8'hA5;
    b0.w_en    = 1'b1;
    tick;
    b0.w_en    = 1'b0;
    ref_mem[3] = 8'hA5;
    tick;
    chk("cpu_rd_a5", b0.r_data, 8'hA5);

    start_load;
    for (int i = 0; i < DEPTH; i++)
      beat(1'b1, 8'(i));
    chk("full_busy", b0.busy, 1);
    beat(1'b1, 8'hEE);
    exit_load("full_exit");
    check_mem("full_mem");

    old = ref_mem[5];
    d   = 8'($urandom);
    b0.address = 4'd5;
    b0.w_data  = d;
    b0.w_en    = 1'b1;
    tick;
    b0.w_en    = 1'b0;
    chk("rdw_old", b0.r_data, old);
    chk("rdw_byp", b1.r_data, d);
    ref_mem[5] = d;
    tick;
    chk("rdw_after0", b0.r_data, d);
    chk("rdw_after1", b1.r_data, d);

    start_load;
    b0.address = 4'd7;
    b0.w_data  = 8'hFF;
    b0.w_en    = 1'b1;
    for (int i = 0; i < 30; i++)
      beat($urandom_range(0, 3) != 0, 8'($urandom));
    b0.w_en = 1'b0;
    exit_load("gap_exit");
    check_mem("gap_mem");

    b0.address = 4'd7;
    b0.w_data  = 8'hFF;
    b0.w_en    = 1'b1;
    tick;
    b0.w_en    = 1'b0;
    ref_mem[7] = 8'hFF;
    tick;
    chk("cpu_wr7", b0.r_data, 8'hFF);

    start_load;
    for (int i = 0; i < 5; i++)
      beat(1'b1, 8'($urandom));
    exit_load("abort");
    chk("abort_count5", b0.ld_count, 5);
    check_mem("abort_mem");
    start_load;
    for (int i = 0; i < 3; i++)
      beat(1'b1, 8'($urandom));
    exit_load("restart_exit");
    check_mem("restart_mem");

    b0.prog_mode = 1'b1;
    tick;
    b0.prog_mode = 1'b0;
    tick;
    chk("pulse_busy", b0.busy, 1);
    chk("pulse_count", b0.ld_count, 0);
    tick;
    chk("pulse_idle", b0.busy, 0);
    chk("pulse_count_hold", b0.ld_count, 0);
    chk("pulse_done", b0.ld_done, 0);

    start_load;
    for (int i = 0; i < 9; i++)
      beat(1'b1, 8'($urandom));
    b0.ld_valid = 1'b1;
    b0.ld_data  = 8'($urandom);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outs("midrst");
    b0.ld_valid  = 1'b0;
    b0.prog_mode = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("post_rst_busy", b0.busy, 0);
    check_mem("midrst_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
